// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pattern generator and checker: state
// encoding, the XNOR feedback tap table and saturating-counter helpers.
package lfsr_pkg;

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } lfsr_state_e;

   localparam logic [31:0] SAT_32 = 32'hFFFF_FFFF;

   // Tap masks; bit k set means register bit k feeds the XNOR chain.
   function automatic logic [31:0] lfsr_taps(input int num_bits);
      logic [31:0] taps;
      case (num_bits)
         3:       taps = 32'h0000_0006;
         4:       taps = 32'h0000_000C;
         5:       taps = 32'h0000_0014;
         6:       taps = 32'h0000_0030;
         7:       taps = 32'h0000_0060;
         8:       taps = 32'h0000_00B8;
         9:       taps = 32'h0000_0110;
         10:      taps = 32'h0000_0240;
         11:      taps = 32'h0000_0500;
         12:      taps = 32'h0000_0829;
         13:      taps = 32'h0000_100D;
         14:      taps = 32'h0000_2015;
         15:      taps = 32'h0000_6000;
         16:      taps = 32'h0000_D008;
         17:      taps = 32'h0001_2000;
         18:      taps = 32'h0002_0400;
         19:      taps = 32'h0004_0023;
         20:      taps = 32'h0009_0000;
         21:      taps = 32'h0014_0000;
         22:      taps = 32'h0030_0000;
         23:      taps = 32'h0042_0000;
         24:      taps = 32'h00E1_0000;
         25:      taps = 32'h0120_0000;
         26:      taps = 32'h0200_0023;
         27:      taps = 32'h0400_0013;
         28:      taps = 32'h0900_0000;
         29:      taps = 32'h1400_0000;
         30:      taps = 32'h2000_0029;
         31:      taps = 32'h4800_0000;
         32:      taps = 32'h8020_0003;
         default: taps = 32'h0000_0000;
      endcase
      return taps;
   endfunction

   // Every entry has an even tap count, so the XNOR chain equals inverted parity.
   function automatic logic [31:0] lfsr_next(input logic [31:0] state, input int num_bits);
      logic [31:0] width_mask;
      logic        fb;
      width_mask = (num_bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << num_bits) - 32'd1);
      fb         = ~(^(state & lfsr_taps(num_bits)));
      return ((state << 1) | {31'd0, fb}) & width_mask;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? SAT_32 : sum[31:0];
   endfunction

endpackage

// File: rtl/lfsr_checker_popcount.sv
// Number of set bits in a word of up to 32 bits; used to count bit errors
// when LFSR_CHECKER_BIT_ERR_EN is defined.
module lfsr_popcount #(
   parameter int W = 16
) (
   input  logic [W-1:0] vec_i,
   output logic [5:0]   count_o
);

   // Ripple sum of the individual bits.
   always_comb begin
      count_o = 6'd0;
      for (int i = 0; i < W; i++) begin
         count_o = count_o + {5'd0, vec_i[i]};
      end
   end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising receive-side LFSR checker with error/word statistics.
// Define LFSR_CHECKER_BIT_ERR_EN to build the per-bit error counter.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int NUM_BITS      = 16,
   parameter int LOCK_COUNT    = 16,
   parameter int UNLOCK_MISSES = 4
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic                i_Enable,
   input  logic                i_Valid,
   input  logic [NUM_BITS-1:0] i_Data,
   input  logic                i_Clear,
   output logic                o_Locked,
   output logic                o_Error,
   output logic [31:0]         o_Error_Count,
   output logic [31:0]         o_Word_Count,
   output logic [31:0]         o_Bit_Err_Count
);

   localparam logic [NUM_BITS-1:0] ALL_ONES   = {NUM_BITS{1'b1}};
   localparam logic [7:0]          LOCK_CNT   = 8'(LOCK_COUNT);
   localparam logic [7:0]          UNLOCK_CNT = 8'(UNLOCK_MISSES);

   function automatic logic [NUM_BITS-1:0] next_word(input logic [NUM_BITS-1:0] s);
      logic [31:0] wide;
      wide = lfsr_next(32'(s), NUM_BITS);
      return NUM_BITS'(wide);
   endfunction

   lfsr_state_e         state_q, state_d;
   logic [NUM_BITS-1:0] pred_q, pred_d;
   logic [7:0]          match_q, match_d;
   logic [7:0]          miss_q, miss_d;
   logic                locked_q, locked_d;
   logic                error_q, error_d;
   logic [31:0]         err_cnt_q, err_cnt_d;
   logic [31:0]         word_cnt_q, word_cnt_d;
   logic                err_evt_s;
   logic                clear_s;

   assign err_evt_s = i_Enable && i_Valid && (state_q == LOCKED) && (i_Data != pred_q);
   assign clear_s   = i_Enable && i_Clear;

   // Acquisition / tracking state machine and statistics next-state.
   always_comb begin
      state_d    = state_q;
      pred_d     = pred_q;
      match_d    = match_q;
      miss_d     = miss_q;
      error_d    = 1'b0;
      err_cnt_d  = err_cnt_q;
      word_cnt_d = word_cnt_q;
      if (i_Enable && i_Valid) begin
         case (state_q)
            SEED: begin
               if (i_Data != ALL_ONES) begin
                  pred_d  = next_word(i_Data);
                  match_d = 8'd0;
                  state_d = VERIFY;
               end else begin
                  state_d = SEED;
               end
            end
            VERIFY: begin
               if (i_Data == pred_q) begin
                  pred_d  = next_word(pred_q);
                  match_d = match_q + 8'd1;
                  if ((match_q + 8'd1) == LOCK_CNT) begin
                     state_d = LOCKED;
                     miss_d  = 8'd0;
                  end else begin
                     state_d = VERIFY;
                  end
               end else if (i_Data == ALL_ONES) begin
                  state_d = SEED;
               end else begin
                  pred_d  = next_word(i_Data);
                  match_d = 8'd0;
               end
            end
            LOCKED: begin
               // Flywheel: the prediction advances whether or not the word matched.
               pred_d     = next_word(pred_q);
               word_cnt_d = sat_add(word_cnt_q, 32'd1);
               if (err_evt_s) begin
                  error_d   = 1'b1;
                  err_cnt_d = sat_add(err_cnt_q, 32'd1);
                  if ((miss_q + 8'd1) == UNLOCK_CNT) begin
                     state_d = SEED;
                     miss_d  = 8'd0;
                  end else begin
                     miss_d = miss_q + 8'd1;
                  end
               end else begin
                  miss_d = 8'd0;
               end
            end
            default: state_d = SEED;
         endcase
      end else begin
         error_d = 1'b0;
      end
      err_cnt_d  = clear_s ? 32'd0 : err_cnt_d;
      word_cnt_d = clear_s ? 32'd0 : word_cnt_d;
      locked_d   = (state_d == LOCKED);
   end

   // State and statistics registers.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q    <= SEED;
         pred_q     <= {NUM_BITS{1'b0}};
         match_q    <= 8'd0;
         miss_q     <= 8'd0;
         locked_q   <= 1'b0;
         error_q    <= 1'b0;
         err_cnt_q  <= 32'd0;
         word_cnt_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         pred_q     <= pred_d;
         match_q    <= match_d;
         miss_q     <= miss_d;
         locked_q   <= locked_d;
         error_q    <= error_d;
         err_cnt_q  <= err_cnt_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign o_Locked      = locked_q;
   assign o_Error       = error_q;
   assign o_Error_Count = err_cnt_q;
   assign o_Word_Count  = word_cnt_q;

`ifdef LFSR_CHECKER_BIT_ERR_EN
   logic [5:0]  pop_s;
   logic [31:0] bit_err_q, bit_err_d;

   lfsr_popcount #(.W(NUM_BITS)) u_popcount (
      .vec_i   (i_Data ^ pred_q),
      .count_o (pop_s)
   );

   // Accumulate erroneous bits of mismatching locked words.
   always_comb begin
      if (clear_s) begin
         bit_err_d = 32'd0;
      end else if (err_evt_s) begin
         bit_err_d = sat_add(bit_err_q, {26'd0, pop_s});
      end else begin
         bit_err_d = bit_err_q;
      end
   end

   // Bit-error counter register.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         bit_err_q <= 32'd0;
      end else begin
         bit_err_q <= bit_err_d;
      end
   end

   assign o_Bit_Err_Count = bit_err_q;
`else
   assign o_Bit_Err_Count = 32'd0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker (NUM_BITS=8, LOCK_COUNT=4, UNLOCK_MISSES=4).
module tb_lfsr_checker;

   localparam int LOCKN   = 4;
   localparam int UNLOCKN = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        v;
   logic [7:0]  d;
   logic        clr;
   logic        locked;
   logic        error;
   logic [31:0] err_cnt;
   logic [31:0] word_cnt;
   logic [31:0] bit_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   lfsr_checker #(.NUM_BITS(8), .LOCK_COUNT(LOCKN), .UNLOCK_MISSES(UNLOCKN)) dut (
      .i_Clk           (clk),
      .i_Rst           (rst),
      .i_Enable        (en),
      .i_Valid         (v),
      .i_Data          (d),
      .i_Clear         (clr),
      .o_Locked        (locked),
      .o_Error         (error),
      .o_Error_Count   (err_cnt),
      .o_Word_Count    (word_cnt),
      .o_Bit_Err_Count (bit_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        locked;
      logic        error;
      logic [31:0] ec;
      logic [31:0] wc;
      logic [31:0] bc;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: 0 = hunting for seed, 1 = verifying, 2 = locked.
   int          m_mode;
   logic [7:0]  m_pred;
   int          m_match;
   int          m_miss;
   bit          m_error;
   longint      m_ec, m_wc, m_bc;

   // 8-bit generator polynomial: XNOR of taps 8,6,5,4 (1-based), shifted in at bit 0.
   function automatic logic [7:0] mnext(input logic [7:0] s);
      logic x;
      x = s[7];
      x = ~(x ^ s[5]);
      x = ~(x ^ s[4]);
      x = ~(x ^ s[3]);
      return {s[6:0], x};
   endfunction

   function automatic longint sat(input longint a);
      return (a > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : a;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pred = 8'h00; m_match = 0; m_miss = 0;
      m_error = 1'b0; m_ec = 0; m_wc = 0; m_bc = 0;
   endtask

   task automatic model_step(input bit men, input bit mv, input logic [7:0] md, input bit mclr);
      m_error = 1'b0;
      if (!men) return;
      if (mv) begin
         if (m_mode == 0) begin
            if (md != 8'hFF) begin m_pred = mnext(md); m_match = 0; m_mode = 1; end
         end else if (m_mode == 1) begin
            if (md == m_pred) begin
               m_match++;
               m_pred = mnext(m_pred);
               if (m_match == LOCKN) begin m_mode = 2; m_miss = 0; end
            end else if (md == 8'hFF) begin
               m_mode = 0;
            end else begin
               m_pred = mnext(md); m_match = 0;
            end
         end else begin
            m_wc = sat(m_wc + 1);
            if (md != m_pred) begin
               m_error = 1'b1;
               m_ec = sat(m_ec + 1);
`ifdef LFSR_CHECKER_BIT_ERR_EN
               m_bc = sat(m_bc + $countones(md ^ m_pred));
`endif
               m_miss++;
               if (m_miss == UNLOCKN) m_mode = 0;
            end else begin
               m_miss = 0;
            end
            m_pred = mnext(m_pred);
         end
      end
      if (mclr) begin m_ec = 0; m_wc = 0; m_bc = 0; end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of stimulus and queue the outputs the model expects after the edge.
   task automatic drive(input bit men, input bit mv, input logic [7:0] md, input bit mclr);
      exp_t e;
      @(negedge clk);
      en = men; v = mv; d = md; clr = mclr;
      model_step(men, mv, md, mclr);
      e.locked = (m_mode == 2);
      e.error  = m_error;
      e.ec     = m_ec[31:0];
      e.wc     = m_wc[31:0];
      e.bc     = m_bc[31:0];
      exp_q.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_locked"}, {31'd0, locked}, 32'd0);
      check({tag, "_error"},  {31'd0, error},  32'd0);
      check({tag, "_errcnt"}, err_cnt,  32'd0);
      check({tag, "_wordcnt"}, word_cnt, 32'd0);
      check({tag, "_bitcnt"}, bit_cnt,  32'd0);
   endtask

   // Monitor: compare DUT outputs against the queued expectation after each edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("locked",  {31'd0, locked}, {31'd0, e.locked});
         check("error",   {31'd0, error},  {31'd0, e.error});
         check("err_cnt", err_cnt,  e.ec);
         check("word_cnt", word_cnt, e.wc);
         check("bit_cnt", bit_cnt,  e.bc);
      end
   end

   logic [7:0] src;

   initial begin
      rst = 1'b1; en = 1'b1; v = 1'b0; d = 8'h00; clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Acquire from the 0x00 seed, including a gap in i_Valid.
      src = 8'h00;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, src, 1'b0);
         src = mnext(src);
      end
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 1'b1, src, 1'b0); src = mnext(src);

      // Single corrupted word (bit 0), flywheel keeps following words clean.
      drive(1'b1, 1'b1, src ^ 8'h01, 1'b0); src = mnext(src);
      for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b1, src, 1'b0); src = mnext(src); end

      // Disabled cycles hold everything, even with clear and bad data.
      drive(1'b0, 1'b1, src ^ 8'h55, 1'b1);
      drive(1'b0, 1'b1, src, 1'b0);
      drive(1'b1, 1'b1, src, 1'b0); src = mnext(src);

      // Clear coinciding with a mismatch.
      drive(1'b1, 1'b1, src ^ 8'h80, 1'b1); src = mnext(src);
      for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b1, src, 1'b0); src = mnext(src); end

      // Four consecutive corrupted words force re-acquisition.
      for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b1, src ^ 8'h03, 1'b0); src = mnext(src); end
      drive(1'b1, 1'b0, 8'h00, 1'b0);

      // All-ones is refused as a seed, then 0x00 is accepted.
      drive(1'b1, 1'b1, 8'hFF, 1'b0);
      src = 8'h00;
      for (int i = 0; i < 7; i++) begin drive(1'b1, 1'b1, src, 1'b0); src = mnext(src); end

      // Asynchronous reset in the middle of a word, then re-lock from a new seed.
      drive(1'b1, 1'b1, src, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      check("queue_at_rst", exp_q.size(), 32'd0);
      model_reset();
      v = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      src = 8'h5A;
      for (int i = 0; i < 7; i++) begin drive(1'b1, 1'b1, src, 1'b0); src = mnext(src); end

      // Randomised stream: gaps, corruptions, jumps, clears and stalls.
      for (int i = 0; i < 800; i++) begin
         bit          r_en, r_v, r_clr;
         logic [7:0]  r_d;
         r_en  = ($urandom_range(0, 29) != 0);
         r_v   = ($urandom_range(0, 3) != 0);
         r_clr = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 199) == 0) begin
            src = 8'($urandom_range(0, 254));
         end
         r_d = src;
         if ($urandom_range(0, 9) == 0) r_d = src ^ 8'($urandom_range(1, 255));
         if ($urandom_range(0, 299) == 0) r_d = 8'hFF;
         drive(r_en, r_v, r_d, r_clr);
         if (r_en && r_v) src = mnext(src);
      end
      drive(1'b1, 1'b0, 8'h00, 1'b0);

      @(posedge clk);
      #3;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
